// File: rtl/vrf_write_arbiter_if.sv
// Write-port bundle for the vector register file arbiter: pipeline writeback,
// loader beat stream, arbitrated VRF write port and hazard/status outputs.
interface vrf_write_arbiter_if #(
    parameter int unsigned V = 256,
    parameter int unsigned R = 5,
    parameter int unsigned W = 32
);
    logic         pipe_we;
    logic [R-1:0] pipe_wa;
    logic [V-1:0] pipe_wd;
    logic         ldr_valid;
    logic         ldr_ready;
    logic [R-1:0] ldr_addr;
    logic [W-1:0] ldr_word;
    logic         ldr_abort;
    logic         vwe;
    logic [R-1:0] vwa;
    logic [V-1:0] vwd;
    logic         stall_req;
    logic         done;

    modport master (
        output pipe_we, pipe_wa, pipe_wd, ldr_valid, ldr_addr, ldr_word, ldr_abort,
        input  ldr_ready, vwe, vwa, vwd, stall_req, done
    );

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd, ldr_valid, ldr_addr, ldr_word, ldr_abort,
        output ldr_ready, vwe, vwa, vwd, stall_req, done
    );
endinterface

// File: rtl/vrf_write_arbiter.sv
// Shares one VRF write port between pipeline writeback (always wins) and a
// beat-serial vector loader that assembles V/W words before committing.
module vrf_write_arbiter #(
    parameter int unsigned V        = 256,
    parameter int unsigned R        = 5,
    parameter int unsigned W        = 32,
    parameter int unsigned STALL_TH = 4
) (
    input logic                clk,
    input logic                rst,
    vrf_write_arbiter_if.slave bus
);
    localparam int unsigned BEATS = V / W;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WW    = (STALL_TH > 0) ? $clog2(STALL_TH + 1) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [V-1:0]  buf_q, buf_d;
    logic [R-1:0]  addr_q, addr_d;
    logic          stall_q, stall_d;
    logic          done_q, done_d;
    logic          ready;
    logic          accept;

    // Held low during reset so no beat can be taken while the FSM is forced idle.
    assign ready         = rst && (state_q != WRITE);
    assign accept        = bus.ldr_valid && ready;
    assign bus.ldr_ready = ready;
    assign bus.stall_req = stall_q;
    assign bus.done      = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            stall_q <= stall_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        if (bus.ldr_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            wait_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        buf_d[W-1:0] = bus.ldr_word;
                        addr_d       = bus.ldr_addr;
                        cnt_d        = (BEATS == 1) ? '0 : CW'(1);
                        wait_d       = '0;
                        state_d      = (BEATS == 1) ? WRITE : COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        for (int unsigned k = 1; k < BEATS; k++) begin
                            if (cnt_q == CW'(k)) buf_d[k*W +: W] = bus.ldr_word;
                        end
                        if (cnt_q == CW'(BEATS - 1)) begin
                            state_d = WRITE;
                            cnt_d   = '0;
                            wait_d  = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.pipe_we) begin
                        if (wait_q < WW'(STALL_TH)) wait_d = wait_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        wait_d  = '0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Registered stall tracks the post-edge WRITE occupancy, so it drops on exit.
        stall_d = (state_d == WRITE) && (wait_d >= WW'(STALL_TH));
    end

    always_comb begin
        bus.vwe = 1'b0;
        bus.vwa = '0;
        bus.vwd = '0;
        if (rst) begin
            if (bus.pipe_we) begin
                bus.vwe = 1'b1;
                bus.vwa = bus.pipe_wa;
                bus.vwd = bus.pipe_wd;
            end else if (state_q == WRITE && !bus.ldr_abort) begin
                bus.vwe = 1'b1;
                bus.vwa = addr_q;
                bus.vwd = buf_q;
            end
        end
    end
endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Randomized and directed bench for vrf_write_arbiter against a queue-based
// model of the loader vector and the write-port priority rules.
module tb_vrf_write_arbiter;
    localparam int unsigned V = 256;
    localparam int unsigned R = 5;
    localparam int unsigned W = 32;
    localparam int unsigned TH = 4;
    localparam int unsigned BEATS = V / W;

    typedef struct packed {
        logic         we;
        logic [R-1:0] wa;
        logic [V-1:0] wd;
        logic         valid;
        logic [R-1:0] addr;
        logic [W-1:0] word;
        logic         abort;
    } stim_t;

    typedef struct packed {
        logic         vwe;
        logic [R-1:0] vwa;
        logic [V-1:0] vwd;
        logic         ready;
        logic         stall;
        logic         done;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vrf_write_arbiter_if #(.V(V), .R(R), .W(W)) bus();
    vrf_write_arbiter #(.V(V), .R(R), .W(W), .STALL_TH(TH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    // Model: the loader vector is just the list of words received so far.
    logic [W-1:0] m_words[$];
    logic [R-1:0] m_addr = '0;
    bit           m_full = 0;
    int unsigned  m_waits = 0;
    bit           m_done = 0;

    function automatic obs_t model_out(stim_t s);
        obs_t o = '0;
        if (rst !== 1'b1) return o;
        o.ready = !m_full;
        o.stall = m_full && (m_waits >= TH);
        o.done  = m_done;
        if (s.we) begin
            o.vwe = 1'b1;
            o.vwa = s.wa;
            o.vwd = s.wd;
        end else if (m_full && !s.abort) begin
            o.vwe = 1'b1;
            o.vwa = m_addr;
            for (int k = 0; k < m_words.size(); k++) o.vwd[k*W +: W] = m_words[k];
        end
        return o;
    endfunction

    function automatic void model_step(stim_t s);
        if (rst !== 1'b1 || s.abort) begin
            m_words.delete();
            m_full  = 0;
            m_waits = 0;
            m_done  = 0;
            if (rst !== 1'b1) m_addr = '0;
            return;
        end
        m_done = 0;
        if (m_full) begin
            if (s.we) begin
                if (m_waits < TH) m_waits++;
            end else begin
                m_full  = 0;
                m_done  = 1;
                m_waits = 0;
                m_words.delete();
            end
        end else if (s.valid) begin
            if (m_words.size() == 0) m_addr = s.addr;
            m_words.push_back(s.word);
            if (m_words.size() == BEATS) begin
                m_full  = 1;
                m_waits = 0;
            end
        end
    endfunction

    function automatic logic [V-1:0] rand_v();
        logic [V-1:0] v;
        for (int k = 0; k < V / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic stim_t idle_s();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t beat_s(logic [R-1:0] a, logic [W-1:0] w);
        stim_t s = '0;
        s.valid = 1'b1;
        s.addr  = a;
        s.word  = w;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.pipe_we   = s.we;
        bus.pipe_wa   = s.wa;
        bus.pipe_wd   = s.wd;
        bus.ldr_valid = s.valid;
        bus.ldr_addr  = s.addr;
        bus.ldr_word  = s.word;
        bus.ldr_abort = s.abort;
    endtask

    task automatic sample(output obs_t o);
        o.vwe   = bus.vwe;
        o.vwa   = bus.vwa;
        o.vwd   = bus.vwd;
        o.ready = bus.ldr_ready;
        o.stall = bus.stall_req;
        o.done  = bus.done;
    endtask

    // Drives one cycle after a falling edge, samples mid-cycle, advances the model.
    task automatic tick(input stim_t s, output obs_t got, output obs_t exp);
        drive(s);
        #1;
        sample(got);
        exp = model_out(s);
        model_step(s);
        @(negedge clk);
    endtask

    logic [V-1:0] ref_v;

    task automatic test_reset();
        stim_t s;
        obs_t got, exp;
        for (int i = 0; i < 3; i++) begin
            s = idle_s();
            s.we = 1'b1; s.wa = 5'd9; s.wd = rand_v(); s.valid = 1'b1;
            tick(s, got, exp);
            n_total++;
            if (got !== '0) $display("FAIL reset_outputs cyc%0d: got=%h exp=%h", i, got, obs_t'(0));
            else n_pass++;
        end
        rst = 1'b1;
        s = idle_s();
        tick(s, got, exp);
        n_total++;
        if (got !== exp) $display("FAIL reset_release: got=%h exp=%h", got, exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        stim_t s;
        obs_t got, exp;
        for (int i = 0; i < 10; i++) begin
            s = (i < 8) ? beat_s((i == 0) ? 5'd3 : 5'($urandom), W'(i + 1)) : idle_s();
            tick(s, got, exp);
            n_total++;
            if (got !== exp) $display("FAIL b2b_model cyc%0d: got=%h exp=%h", i, got, exp);
            else n_pass++;
            if (i == 8) begin
                n_total++;
                if ({got.vwe, got.vwa, got.vwd} !== {1'b1, 5'd3, ref_v})
                    $display("FAIL b2b_write: got vwe=%0b vwa=%0d vwd=%h exp vwe=1 vwa=3 vwd=%h", got.vwe, got.vwa, got.vwd, ref_v);
                else n_pass++;
            end
            if (i == 9) begin
                n_total++;
                if (got.done !== 1'b1) $display("FAIL b2b_done: got=%0b exp=1", got.done);
                else n_pass++;
            end
        end
    endtask

    task automatic test_pipe_contention();
        stim_t s;
        obs_t got, exp;
        for (int i = 0; i < 17; i++) begin
            if (i < 8) s = beat_s((i == 0) ? 5'd5 : 5'($urandom), $urandom);
            else s = idle_s();
            if (i >= 8 && i < 14) begin
                s.we = 1'b1; s.wa = 5'($urandom); s.wd = rand_v();
            end
            tick(s, got, exp);
            n_total++;
            if (got !== exp) $display("FAIL contention_model cyc%0d: got=%h exp=%h", i, got, exp);
            else n_pass++;
            if (i == 11 || i == 12) begin
                n_total++;
                if (got.stall !== (i == 12)) $display("FAIL contention_stall cyc%0d: got=%0b exp=%0b", i, got.stall, i == 12);
                else n_pass++;
            end
            if (i == 14) begin
                n_total++;
                if ({got.vwe, got.vwa} !== {1'b1, 5'd5}) $display("FAIL contention_write: got vwe=%0b vwa=%0d exp vwe=1 vwa=5", got.vwe, got.vwa);
                else n_pass++;
            end
            if (i == 15) begin
                n_total++;
                if ({got.done, got.stall} !== 2'b10) $display("FAIL contention_done: got done=%0b stall=%0b exp done=1 stall=0", got.done, got.stall);
                else n_pass++;
            end
        end
    endtask

    task automatic test_gaps();
        stim_t s;
        obs_t got, exp;
        for (int i = 0; i < 8 * 4 + 2; i++) begin
            s = (i % 4 == 0 && i < 32) ? beat_s(5'd3, W'(i / 4 + 1)) : idle_s();
            if (i % 4 != 0) s.word = $urandom;
            tick(s, got, exp);
            n_total++;
            if (got !== exp) $display("FAIL gaps_model cyc%0d: got=%h exp=%h", i, got, exp);
            else n_pass++;
            if (i < 29) begin
                n_total++;
                if (got.ready !== 1'b1) $display("FAIL gaps_ready cyc%0d: got=%0b exp=1", i, got.ready);
                else n_pass++;
            end
            if (i == 29) begin
                n_total++;
                if ({got.vwe, got.vwa, got.vwd} !== {1'b1, 5'd3, ref_v})
                    $display("FAIL gaps_write: got vwe=%0b vwa=%0d vwd=%h exp vwd=%h", got.vwe, got.vwa, got.vwd, ref_v);
                else n_pass++;
            end
        end
    endtask

    task automatic test_abort();
        stim_t s;
        obs_t got, exp;
        int unsigned writes = 0, dones = 0, bad_addr = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) s = beat_s(5'd2, $urandom);
            else if (i == 4) begin
                s = beat_s(5'd2, $urandom);
                s.abort = 1'b1; s.we = 1'b1; s.wa = 5'd11; s.wd = rand_v();
            end else if (i < 13) s = beat_s((i == 5) ? 5'd7 : 5'($urandom), $urandom);
            else s = idle_s();
            tick(s, got, exp);
            n_total++;
            if (got !== exp) $display("FAIL abort_model cyc%0d: got=%h exp=%h", i, got, exp);
            else n_pass++;
            if (got.vwe && !s.we) begin
                writes++;
                if (got.vwa !== 5'd7) bad_addr++;
            end
            if (got.done) dones++;
        end
        n_total++;
        if (writes != 1 || bad_addr != 0 || dones != 1)
            $display("FAIL abort_summary: got writes=%0d bad_addr=%0d dones=%0d exp writes=1 bad_addr=0 dones=1", writes, bad_addr, dones);
        else n_pass++;
    endtask

    task automatic test_reset_midload();
        stim_t s;
        obs_t got, exp;
        int unsigned writes = 0, dones = 0;
        for (int i = 0; i < 6; i++) begin
            s = beat_s(5'd4, $urandom);
            tick(s, got, exp);
            n_total++;
            if (got !== exp) $display("FAIL midrst_load cyc%0d: got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        s = idle_s();
        s.we = 1'b1; s.wa = 5'd17; s.wd = rand_v();
        drive(s);
        #2 rst = 1'b0;
        #1 sample(got);
        n_total++;
        if (got !== '0) $display("FAIL midrst_async: got=%h exp=%h", got, obs_t'(0));
        else n_pass++;
        model_step(s);
        @(negedge clk);
        tick(s, got, exp);
        n_total++;
        if (got !== exp) $display("FAIL midrst_held: got=%h exp=%h", got, exp);
        else n_pass++;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s = (i >= 6 && i < 14) ? beat_s(5'd6, $urandom) : idle_s();
            tick(s, got, exp);
            n_total++;
            if (got !== exp) $display("FAIL midrst_after cyc%0d: got=%h exp=%h", i, got, exp);
            else n_pass++;
            if (i < 14 && (got.vwe || got.done)) writes++;
            if (i >= 14 && got.vwe && got.vwa === 5'd6) dones++;
        end
        n_total++;
        if (writes != 0 || dones != 1)
            $display("FAIL midrst_summary: got early_activity=%0d reg6_writes=%0d exp 0 and 1", writes, dones);
        else n_pass++;
    endtask

    task automatic test_random();
        stim_t s;
        obs_t got, exp;
        for (int i = 0; i < 1500; i++) begin
            s.we    = ($urandom_range(0, 9) < 3);
            s.wa    = 5'($urandom);
            s.wd    = rand_v();
            s.valid = ($urandom_range(0, 9) < 6);
            s.addr  = 5'($urandom);
            s.word  = $urandom;
            s.abort = ($urandom_range(0, 99) < 3);
            tick(s, got, exp);
            n_total++;
            if (got !== exp) $display("FAIL random_model cyc%0d: got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        for (int k = 0; k < BEATS; k++) ref_v[k*W +: W] = W'(k + 1);
        drive(idle_s());
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_pipe_contention();
        test_gaps();
        test_abort();
        test_reset_midload();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/vrf_write_arbiter.md
VRF_WRITE_ARBITER -- requirements
Module: vrf_write_arbiter

Interface
REQ-001 SHALL have parameter V, default 256, meaning vector register width in bits.
REQ-002 SHALL have parameter R, default 5, meaning register address width.
REQ-003 SHALL have parameter W, default 32, meaning loader word width; V/W (BEATS, 8 at defaults) SHALL be an integer.
REQ-004 SHALL have parameter STALL_TH, default 4, meaning loader wait cycles before a stall request.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port pipe_we  input  1  pipeline vector writeback enable (RegWriteVW).
REQ-008 SHALL have port pipe_wa  input  R  pipeline writeback register address.
REQ-009 SHALL have port pipe_wd  input  V  pipeline writeback data.
REQ-010 SHALL have port ldr_valid  input  1  loader word valid.
REQ-011 SHALL have port ldr_ready  output  1  arbiter can accept a loader word.
REQ-012 SHALL have port ldr_addr  input  R  loader target register, sampled on first beat only.
REQ-013 SHALL have port ldr_word  input  W  loader data word.
REQ-014 SHALL have port ldr_abort  input  1  synchronous discard of an in-progress load.
REQ-015 SHALL have port vwe  output  1  write enable to the vector register file port.
REQ-016 SHALL have port vwa  output  R  write address to the vector register file port.
REQ-017 SHALL have port vwd  output  V  write data to the vector register file port.
REQ-018 SHALL have port stall_req  output  1  request to hazard unit to hold pipeline writeback.
REQ-019 SHALL have port done  output  1  one-cycle pulse: loader vector committed.

Function
REQ-020 SHALL implement FSM states IDLE, COLLECT, WRITE.
REQ-021 A beat SHALL be accepted on a rising edge where ldr_valid and ldr_ready are both 1.
REQ-022 ldr_ready SHALL be 1 in IDLE and COLLECT, 0 in WRITE; it SHALL not depend combinationally on ldr_valid.
REQ-023 IDLE: accepted beat -> word to buffer bits [W-1:0], ldr_addr latched, beat count = 1, next COLLECT.
REQ-024 COLLECT: accepted beat k -> word to buffer bits [W*k+W-1 : W*k]; count increments; beat BEATS-1 accepted -> next WRITE.
REQ-025 COLLECT with ldr_valid low SHALL hold state, count and buffer indefinitely.
REQ-026 Port arbitration (combinational): pipe_we=1 -> vwe=1, vwa=pipe_wa, vwd=pipe_wd, zero-latency pass-through, pipeline always wins.
REQ-027 WRITE with pipe_we=0 -> vwe=1, vwa=latched address, vwd=buffer; next edge -> IDLE, done=1 for exactly the following cycle.
REQ-028 Neither source writing -> vwe=0, vwa=0, vwd=0.
REQ-029 WRITE with pipe_we=1 -> stay in WRITE, wait counter increments (saturating at STALL_TH).
REQ-030 stall_req SHALL be registered: 1 while in WRITE with wait counter >= STALL_TH, else 0; cleared on the edge leaving WRITE.
REQ-031 Wait counter SHALL clear on entering WRITE and on leaving it.
REQ-032 Same register targeted by pipeline and loader: pipeline write occurs first, loader write later overwrites; no merge.
REQ-033 ldr_abort=1 in any state SHALL take precedence: next edge -> IDLE, count=0, wait=0, stall_req=0, no done, no loader write that cycle (pipeline pass-through unaffected); beat presented same cycle is dropped.
REQ-034 Buffer contents after abort or done are don't-care; a new load overwrites all beats.

Reset
REQ-035 rst=0 SHALL immediately force IDLE, count=0, wait=0, stall_req=0, done=0, buffer and latched address=0.
REQ-036 During reset, ldr_ready=0; vwe/vwa/vwd=0 regardless of pipe_we.
REQ-037 Reset mid-load SHALL discard the partial vector; no write and no done after release.
REQ-038 After release, first accepted beat SHALL be treated as beat 0.

Verification
REQ-039 8 back-to-back beats 0x00000001..0x00000008, ldr_addr=3, pipe_we=0 -> vwe=1, vwa=3, vwd[31:0]=1 ... vwd[255:224]=8 in cycle after 8th beat; done next cycle.
REQ-040 Load to reg 5 while pipe_we=1 for 6 cycles in WRITE -> vwa=pipe_wa those cycles, stall_req=1 from 5th WRITE cycle, loader write on first pipe_we=0 cycle, then done, stall_req=0.
REQ-041 ldr_valid gaps of 3 cycles between beats -> identical result to REQ-039; ldr_ready stays 1.
REQ-042 ldr_abort after beat 4, then fresh 8-beat load to reg 7 -> only reg 7 written, one done pulse.
REQ-043 rst=0 asserted after beat 6 -> outputs zero immediately; after release no write or done until 8 new beats.
